// File: rtl/tap_ir_ctrl_if.sv
// rtl/tap_ir_ctrl_if.sv - JTAG serial pin bundle between the test port and the TAP controller
interface tap_ir_ctrl_if;
  logic tms;
  logic tdi;
  logic tdo;
  logic tdo_en;

  modport master (output tms, output tdi, input tdo, input tdo_en);
  modport slave  (input tms, input tdi, output tdo, output tdo_en);
endinterface

// File: rtl/tap_ir_ctrl.sv
// rtl/tap_ir_ctrl.sv - IEEE 1149.1 TAP state machine with instruction register and state strobes
module tap_ir_ctrl #(
  parameter int                  IR_WIDTH   = 4,
  parameter logic [IR_WIDTH-1:0] IR_CAPTURE = 4'b0001,
  parameter logic [IR_WIDTH-1:0] IR_RESET   = 4'b0000
) (
  input  logic                tck,
  input  logic                trst_n,
  tap_ir_ctrl_if.slave        jtag,
  input  logic                dr_tdo,
  output logic [IR_WIDTH-1:0] ir_out,
  output logic [3:0]          tap_state,
  output logic                test_logic_reset,
  output logic                run_idle,
  output logic                capture_dr,
  output logic                shift_dr,
  output logic                update_dr,
  output logic                capture_ir,
  output logic                shift_ir,
  output logic                update_ir
);

  typedef enum logic [3:0] {
    TLR      = 4'd0,  RTI      = 4'd1,  SEL_DR   = 4'd2,  CAP_DR   = 4'd3,
    SHIFT_DR = 4'd4,  EXIT1_DR = 4'd5,  PAUSE_DR = 4'd6,  EXIT2_DR = 4'd7,
    UPD_DR   = 4'd8,  SEL_IR   = 4'd9,  CAP_IR   = 4'd10, SHIFT_IR = 4'd11,
    EXIT1_IR = 4'd12, PAUSE_IR = 4'd13, EXIT2_IR = 4'd14, UPD_IR   = 4'd15
  } tap_state_t;

  tap_state_t          state;
  tap_state_t          next_state;
  logic [IR_WIDTH-1:0] ir_sr;
  logic                tdo_en_q;

  always_comb begin
    next_state = TLR;
    case (state)
      TLR:      next_state = jtag.tms ? TLR      : RTI;
      RTI:      next_state = jtag.tms ? SEL_DR   : RTI;
      SEL_DR:   next_state = jtag.tms ? SEL_IR   : CAP_DR;
      CAP_DR:   next_state = jtag.tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: next_state = jtag.tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: next_state = jtag.tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: next_state = jtag.tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: next_state = jtag.tms ? UPD_DR   : SHIFT_DR;
      UPD_DR:   next_state = jtag.tms ? SEL_DR   : RTI;
      SEL_IR:   next_state = jtag.tms ? TLR      : CAP_IR;
      CAP_IR:   next_state = jtag.tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: next_state = jtag.tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: next_state = jtag.tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: next_state = jtag.tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: next_state = jtag.tms ? UPD_IR   : SHIFT_IR;
      UPD_IR:   next_state = jtag.tms ? SEL_DR   : RTI;
      default:  next_state = TLR;
    endcase
  end

  // Strobes are registered from next_state so they equal a decode of the registered state.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      state            <= TLR;
      ir_sr            <= IR_CAPTURE;
      ir_out           <= IR_RESET;
      test_logic_reset <= 1'b1;
      run_idle         <= 1'b0;
      capture_dr       <= 1'b0;
      shift_dr         <= 1'b0;
      update_dr        <= 1'b0;
      capture_ir       <= 1'b0;
      shift_ir         <= 1'b0;
      update_ir        <= 1'b0;
      tdo_en_q         <= 1'b0;
    end else begin
      state <= next_state;

      case (state)
        CAP_IR:   ir_sr <= IR_CAPTURE;
        SHIFT_IR: ir_sr <= {jtag.tdi, ir_sr[IR_WIDTH-1:1]};
        default:  ir_sr <= ir_sr;
      endcase

      case (state)
        UPD_IR:  ir_out <= ir_sr;
        TLR:     ir_out <= IR_RESET;
        default: ir_out <= ir_out;
      endcase

      test_logic_reset <= (next_state == TLR);
      run_idle         <= (next_state == RTI);
      capture_dr       <= (next_state == CAP_DR);
      shift_dr         <= (next_state == SHIFT_DR);
      update_dr        <= (next_state == UPD_DR);
      capture_ir       <= (next_state == CAP_IR);
      shift_ir         <= (next_state == SHIFT_IR);
      update_ir        <= (next_state == UPD_IR);
      tdo_en_q         <= (next_state == SHIFT_DR) || (next_state == SHIFT_IR);
    end
  end

  assign tap_state   = state;
  assign jtag.tdo_en = tdo_en_q;
  assign jtag.tdo    = shift_ir ? ir_sr[0] : (shift_dr ? dr_tdo : 1'b0);

endmodule

// File: tb/tb_tap_ir_ctrl.sv
// tb/tb_tap_ir_ctrl.sv - directed bench for tap_ir_ctrl
module tb_tap_ir_ctrl;
  logic       tck = 1'b0;
  logic       trst_n;
  logic       dr_tdo;
  logic [3:0] ir_out;
  logic [3:0] tap_state;
  logic       test_logic_reset, run_idle, capture_dr, shift_dr, update_dr;
  logic       capture_ir, shift_ir, update_ir;

  int total = 0;
  int bad   = 0;

  logic [3:0] ir_val;
  logic [3:0] tdo_exp;
  int         ones_seq [5] = '{5, 8, 2, 9, 0};

  tap_ir_ctrl_if jtag ();

  tap_ir_ctrl dut (
    .tck              (tck),
    .trst_n           (trst_n),
    .jtag             (jtag),
    .dr_tdo           (dr_tdo),
    .ir_out           (ir_out),
    .tap_state        (tap_state),
    .test_logic_reset (test_logic_reset),
    .run_idle         (run_idle),
    .capture_dr       (capture_dr),
    .shift_dr         (shift_dr),
    .update_dr        (update_dr),
    .capture_ir       (capture_ir),
    .shift_ir         (shift_ir),
    .update_ir        (update_ir)
  );

  always #5 tck = ~tck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic t, input logic d);
    jtag.tms = t;
    jtag.tdi = d;
    @(posedge tck);
    #1;
  endtask

  task automatic load_ir(input logic [3:0] v);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(i == 3, v[i]);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    trst_n   = 1'b0;
    jtag.tms = 1'b1;
    jtag.tdi = 1'b0;
    dr_tdo   = 1'b0;
    repeat (2) @(posedge tck);
    #1;
    chk("rst_state", tap_state, 0);
    chk("rst_ir_out", ir_out, 4'b0000);
    chk("rst_tdo_en", jtag.tdo_en, 0);
    chk("rst_tlr", test_logic_reset, 1);
    chk("rst_tdo", jtag.tdo, 0);
    chk("rst_rti", run_idle, 0);

    trst_n = 1'b1;
    step(1'b0, 1'b0);
    chk("release_state", tap_state, 1);
    chk("release_rti", run_idle, 1);
    chk("release_tlr", test_logic_reset, 0);

    // IR load 1010 with capture value observed on tdo
    ir_val  = 4'b1010;
    tdo_exp = 4'b0001;
    step(1'b1, 1'b0);
    chk("ir_sel_dr", tap_state, 2);
    step(1'b1, 1'b0);
    chk("ir_sel_ir", tap_state, 9);
    step(1'b0, 1'b0);
    chk("ir_cap_state", tap_state, 10);
    chk("ir_cap_strobe", capture_ir, 1);
    step(1'b0, 1'b0);
    chk("ir_shift_state", tap_state, 11);
    chk("ir_shift_en", jtag.tdo_en, 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ir_tdo_%0d", i), jtag.tdo, tdo_exp[i]);
      chk($sformatf("ir_out_hold_%0d", i), ir_out, 4'b0000);
      step(i == 3, ir_val[i]);
    end
    chk("ir_exit1", tap_state, 12);
    chk("ir_exit1_tdo_en", jtag.tdo_en, 0);
    step(1'b1, 1'b0);
    chk("ir_upd_strobe", update_ir, 1);
    chk("ir_out_pre_upd", ir_out, 4'b0000);
    step(1'b0, 1'b0);
    chk("ir_back_rti", tap_state, 1);
    chk("ir_out_1010", ir_out, 4'b1010);

    // Pause mid-shift while loading 0110
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("p_sr_1", dut.ir_sr, 4'b0000);
    step(1'b1, 1'b1);
    chk("p_exit1", tap_state, 12);
    chk("p_sr_2", dut.ir_sr, 4'b1000);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      chk($sformatf("p_pause_state_%0d", i), tap_state, 13);
      chk($sformatf("p_pause_sr_%0d", i), dut.ir_sr, 4'b1000);
      chk($sformatf("p_pause_out_%0d", i), ir_out, 4'b1010);
    end
    step(1'b1, 1'b0);
    chk("p_exit2", tap_state, 14);
    step(1'b0, 1'b0);
    chk("p_reshift", tap_state, 11);
    chk("p_resume_sr", dut.ir_sr, 4'b1000);
    chk("p_resume_tdo", jtag.tdo, 0);
    step(1'b0, 1'b1);
    chk("p_sr_3", dut.ir_sr, 4'b1100);
    step(1'b1, 1'b0);
    chk("p_sr_4", dut.ir_sr, 4'b0110);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("p_ir_out_0110", ir_out, 4'b0110);

    // DR path
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("dr_cap_state", tap_state, 3);
    chk("dr_cap_strobe", capture_dr, 1);
    chk("dr_cap_tdo_en", jtag.tdo_en, 0);
    step(1'b0, 1'b0);
    chk("dr_cap_once", capture_dr, 0);
    for (int i = 0; i < 3; i++) begin
      dr_tdo = (i % 2 == 0);
      #1;
      chk($sformatf("dr_shift_%0d", i), shift_dr, 1);
      chk($sformatf("dr_tdo_en_%0d", i), jtag.tdo_en, 1);
      chk($sformatf("dr_tdo_%0d", i), jtag.tdo, (i % 2 == 0) ? 1 : 0);
      step(i == 2, 1'b0);
    end
    chk("dr_exit1", tap_state, 5);
    chk("dr_shift_off", shift_dr, 0);
    chk("dr_tdo_off", jtag.tdo, 0);
    step(1'b1, 1'b0);
    chk("dr_upd_strobe", update_dr, 1);
    step(1'b0, 1'b0);
    chk("dr_upd_once", update_dr, 0);
    chk("dr_ir_out_kept", ir_out, 4'b0110);

    // Asynchronous reset after two shifted IR bits
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("trst_pre_state", tap_state, 11);
    #1;
    trst_n = 1'b0;
    #1;
    chk("trst_state", tap_state, 0);
    chk("trst_tlr", test_logic_reset, 1);
    chk("trst_shift_ir", shift_ir, 0);
    chk("trst_tdo_en", jtag.tdo_en, 0);
    chk("trst_tdo", jtag.tdo, 0);
    chk("trst_ir_out", ir_out, 4'b0000);
    chk("trst_ir_sr", dut.ir_sr, 4'b0001);
    @(posedge tck);
    #1;
    trst_n = 1'b1;
    step(1'b0, 1'b0);
    chk("trst_rel_state", tap_state, 1);
    chk("trst_rel_ir_out", ir_out, 4'b0000);

    // Five consecutive tms=1 edges from SHIFT_DR
    load_ir(4'b1001);
    chk("ones_pre_ir", ir_out, 4'b1001);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("ones_start", tap_state, 4);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0);
      chk($sformatf("ones_state_%0d", i), tap_state, ones_seq[i]);
    end
    chk("ones_tlr_strobe", test_logic_reset, 1);
    step(1'b1, 1'b0);
    chk("ones_stay_tlr", tap_state, 0);
    chk("ones_ir_out", ir_out, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
